// File: rtl/rr_stream_arbiter.sv
// Round-robin packet arbiter: shares one registered valid/ready stage among NUM_REQ streams, locked per packet.
// One-cycle latency, full throughput; a stalled output drops every in_ready and freezes all state.
module rr_stream_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       in_valid,
  input  logic [NUM_REQ*WIDTH-1:0] in_data,
  input  logic [NUM_REQ-1:0]       in_last,
  output logic [NUM_REQ-1:0]       in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_last,
  output logic [IDW-1:0]           out_src,
  input  logic                     out_ready
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] owner;
  logic [IDW-1:0] owner_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] rr_ptr_nxt;
  logic [IDW-1:0] win_idx;
  logic           win_vld;
  logic [IDW-1:0] grant_idx;
  logic           grant_vld;
  logic [WIDTH-1:0] grant_dat;
  logic           stage_free;
  logic           accept;
  logic           acc_last;

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] i);
    return (i == IDW'(NUM_REQ - 1)) ? '0 : i + IDW'(1);
  endfunction

  // Circular priority search starting at rr_ptr.
  always_comb begin : search
    logic [IDW-1:0] idx;
    win_vld = 1'b0;
    win_idx = '0;
    idx     = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_vld && in_valid[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
      idx = wrap_inc(idx);
    end
  end

  assign stage_free = !out_valid || out_ready;
  assign grant_idx  = (state == LOCKED) ? owner : win_idx;
  assign grant_vld  = (state == LOCKED) || win_vld;
  assign accept     = |(in_valid & in_ready);
  assign acc_last   = in_last[grant_idx];

  always_comb begin
    grant_dat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDW'(i)) grant_dat = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    if (accept) begin
      if (acc_last) begin
        state_nxt  = IDLE;
        rr_ptr_nxt = wrap_inc(grant_idx);
      end else begin
        state_nxt = LOCKED;
        owner_nxt = grant_idx;
      end
    end
  end

  // Grant is held back while reset is asserted so upstream never sees a ready it cannot use.
  always_comb begin
    in_ready = '0;
    if (!rst && grant_vld && stage_free) in_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= grant_dat;
      out_last  <= acc_last;
      out_src   <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  a_ready_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));
  a_stall_hold   : assert property (@(posedge clk) disable iff (rst)
                                    (out_valid && !out_ready) |=> ($stable(out_data) && out_valid));

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Bench for rr_stream_arbiter: packet-level reference model checked every cycle plus directed literal checks.
module tb_rr_stream_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   in_valid = '0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_last = '0;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [1:0]     out_src;
  logic           out_ready = 1'b1;

  int n_chk = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  rr_stream_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_src(out_src), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Reference model: packet-level view (locked owner or -1, pointer, output register contents).
  int         m_owner = -1;
  int         m_ptr   = 0;
  bit         m_ov    = 1'b0;
  logic [W-1:0] m_od  = '0;
  bit         m_ol    = 1'b0;
  int         m_os    = 0;

  function automatic int m_grant();
    if (m_owner >= 0) return m_owner;
    for (int k = 0; k < N; k++)
      if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = m_grant();
    if (!rst && g >= 0 && (!m_ov || out_ready)) r[g] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_ov = 1'b0; m_od = '0; m_ol = 1'b0; m_os = 0;
    end else begin
      logic [N-1:0] r;
      int g;
      r = m_ready();
      g = m_grant();
      if (g >= 0 && r[g] && in_valid[g]) begin
        m_ov = 1'b1;
        m_od = in_data[g*W +: W];
        m_ol = in_last[g];
        m_os = g;
        if (in_last[g]) begin
          m_owner = -1;
          m_ptr   = (g + 1) % N;
        end else begin
          m_owner = g;
        end
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model in_ready", 32'(in_ready), 32'(m_ready()));
      chk("model out_valid", 32'(out_valid), 32'(m_ov));
      chk("model out_data", out_data, m_od);
      chk("model out_last", 32'(out_last), 32'(m_ol));
      chk("model out_src", 32'(out_src), 32'(m_os));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int i, input logic [W-1:0] d, input logic l);
    in_data[i*W +: W] = d;
    in_last[i]        = l;
  endtask

  task automatic chk_out(input string nm, input logic [W-1:0] d, input int src, input logic l);
    chk({nm, " valid"}, 32'(out_valid), 32'd1);
    chk({nm, " data"}, out_data, d);
    chk({nm, " src"}, 32'(out_src), 32'(src));
    chk({nm, " last"}, 32'(out_last), 32'(l));
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Round-robin order with all requesters valid and single-beat packets.
    in_valid = 4'b1111;
    for (int i = 0; i < N; i++) beat(i, 32'hA0 + i, 1'b1);
    #1 chk("rr first ready", 32'(in_ready), 32'b0001);
    for (int k = 0; k < 5; k++) begin
      step();
      chk_out("rr seq", 32'hA0 + (k % N), k % N, 1'b1);
    end

    // Advance pointer to 2, then lock on a 3-beat packet from 2 while 1 also requests.
    in_valid = 4'b0010; beat(1, 32'hB0, 1'b1);
    step();
    chk_out("ptr setup", 32'hB0, 1, 1'b1);
    in_valid = 4'b0110; beat(2, 32'h10, 1'b0); beat(1, 32'hB1, 1'b1);
    #1 chk("lock ready0", 32'(in_ready), 32'b0100);
    step();
    chk_out("lock b0", 32'h10, 2, 1'b0);
    beat(2, 32'h11, 1'b0);
    #1 chk("lock ready1", 32'(in_ready), 32'b0100);
    step();
    chk_out("lock b1", 32'h11, 2, 1'b0);
    beat(2, 32'h12, 1'b1);
    #1 chk("lock ready2", 32'(in_ready), 32'b0100);
    step();
    chk_out("lock b2", 32'h12, 2, 1'b1);
    in_valid = 4'b1011; beat(3, 32'hC3, 1'b1); beat(0, 32'hC0, 1'b1);
    #1 chk("after lock ready", 32'(in_ready), 32'b1000);
    step();
    chk_out("after lock", 32'hC3, 3, 1'b1);

    // Backpressure: pointer wrapped to 0, hold 0x55 for five stalled cycles.
    in_valid = 4'b0001; beat(0, 32'h55, 1'b1);
    #1 chk("wrap ready", 32'(in_ready), 32'b0001);
    step();
    chk_out("bp load", 32'h55, 0, 1'b1);
    out_ready = 1'b0;
    in_valid = 4'b0010; beat(1, 32'h66, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1 chk("bp ready", 32'(in_ready), 32'b0000);
      step();
      chk_out("bp hold", 32'h55, 0, 1'b1);
    end
    out_ready = 1'b1;
    #1 chk("bp release ready", 32'(in_ready), 32'b0010);
    step();
    chk_out("bp pass", 32'h66, 1, 1'b1);

    // Owner bubble: owner 0 drops valid mid-packet while 3 waits.
    in_valid = 4'b0001; beat(0, 32'h70, 1'b0);
    step();
    chk_out("bub b0", 32'h70, 0, 1'b0);
    in_valid = 4'b1000; beat(3, 32'h33, 1'b1);
    #1 chk("bub ready", 32'(in_ready), 32'b0001);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("bub drained", 32'(out_valid), 32'd0);
      chk("bub ready hold", 32'(in_ready), 32'b0001);
    end
    in_valid = 4'b1001; beat(0, 32'h71, 1'b1);
    step();
    chk_out("bub b1", 32'h71, 0, 1'b1);
    in_valid = 4'b1000;
    #1 chk("bub next ready", 32'(in_ready), 32'b1000);
    step();
    chk_out("bub next", 32'h33, 3, 1'b1);

    // Sparse requests: 3 alone (pointer wraps), then 1 alone.
    beat(3, 32'h3A, 1'b1);
    step();
    chk_out("sparse 3", 32'h3A, 3, 1'b1);
    in_valid = 4'b0010; beat(1, 32'h1A, 1'b1);
    step();
    chk_out("sparse 1", 32'h1A, 1, 1'b1);

    // Reset mid-packet while locked with a pending beat.
    in_valid = 4'b0100; beat(2, 32'h20, 1'b0);
    step();
    chk_out("pre rst", 32'h20, 2, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_data", out_data, 32'd0);
    chk("rst out_last", 32'(out_last), 32'd0);
    chk("rst out_src", 32'(out_src), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'b0000);
    in_valid = 4'b1111;
    for (int i = 0; i < N; i++) beat(i, 32'hD0 + i, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("post rst ready", 32'(in_ready), 32'b0001);
    step();
    chk_out("post rst", 32'hD0, 0, 1'b1);

    // Mixed vectors checked by the model only.
    for (int k = 0; k < 300; k++) begin
      in_valid  = 4'($urandom);
      in_last   = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
      step();
    end

    in_valid = '0;
    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_stream_arbiter.md
# rr_stream_arbiter

Round-robin arbiter that shares one registered valid/ready pipeline stage among NUM_REQ upstream streams. Each beat carries a last flag, and the arbiter locks onto a requester until that requester's packet ends. It merges several producers onto one downstream consumer with one-beat latency and full throughput. The output stage tags each beat with the source index.

## Interface
- NUM_REQ, 4, number of requesters; legal range is 2..16.
- WIDTH, 32, data width per beat.
- IDW, $clog2(NUM_REQ), width of the source index (derived; not overridden).
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  NUM_REQ  per-requester beat valid.
- in_data  input  NUM_REQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
- in_last  input  NUM_REQ  per-requester end-of-packet flag; qualified by in_valid.
- in_ready  output  NUM_REQ  per-requester accept; at most one bit is high in any cycle.
- out_valid  output  1  registered beat valid.
- out_data  output  WIDTH  registered beat data.
- out_last  output  1  registered end-of-packet flag.
- out_src  output  IDW  index of the requester that supplied the registered beat.
- out_ready  input  1  downstream accept.

## Operation
- Stage free: stage_free = !out_valid || out_ready.
- A beat transfers on an input when in_valid[i] && in_ready[i]. It transfers on the output when out_valid && out_ready.
- State: two states, IDLE and LOCKED, plus owner (IDW bits) and rr_ptr (IDW bits).
- Winner in IDLE:
  - The winner is the first i with in_valid[i] set, searching rr_ptr, rr_ptr+1, …, wrapping at NUM_REQ-1 to 0.
  - The search is combinational.
- in_ready in IDLE: in_ready[winner] = stage_free; all other bits are 0. With no valid requester, in_ready is all 0.
- in_ready in LOCKED: in_ready[owner] = stage_free; all other bits are 0 regardless of their in_valid.
- On an accepted beat from requester w:
  - Load out_data, out_last and out_src=w.
  - Set out_valid=1.
- Packet handling on an accepted beat:
  - If in_last[w]=1: go to or stay in IDLE, and set rr_ptr = (w+1) mod NUM_REQ.
  - If in_last[w]=0: go to LOCKED with owner=w; rr_ptr is unchanged.
- Output consumed with no accept in the same cycle: out_valid goes to 0; out_data, out_last and out_src hold their last values.
- Consume and accept in the same cycle: the registers load the new beat and out_valid stays 1 (pass-through).
- Stall (out_valid && !out_ready):
  - All in_ready bits are 0.
  - out_data, out_last and out_src stay stable.
  - State, owner and rr_ptr hold.
- Arbitration is on packet boundaries only. A single-beat packet (in_last=1) releases the grant immediately.

## Timing
- Reset values while rst is high, applied asynchronously:
  - out_valid=0, out_data=0, out_last=0, out_src=0.
  - State IDLE, owner=0, rr_ptr=0.
  - in_ready all 0.
- Release of rst is synchronous to clk. The first grant can occur in the first cycle after release.
- Latency: a beat accepted at edge k appears on out_* immediately after edge k, so it is visible in cycle k+1.
- Throughput: one beat per cycle, sustained across requester switches. There are no dead cycles at packet boundaries.
- Boundary conditions:
  - Locked owner drops in_valid mid-packet: stay LOCKED, out_valid drains to 0 (a bubble), and other requesters keep in_ready=0 until the owner's last beat is accepted.
  - rr_ptr wrap: a winner of NUM_REQ-1 sets rr_ptr to 0.
  - All NUM_REQ valid continuously with single-beat packets: grants run strictly rr_ptr, rr_ptr+1, … with no requester granted twice in NUM_REQ consecutive grants.
  - in_valid from a non-granted requester is ignored and does not change any state.
  - Reset mid-packet: the lock is cleared and the registered beat is discarded (out_valid=0). Upstream must restart its packet.
- in_ready depends combinationally on in_valid (IDLE), out_valid and out_ready. in_ready has no combinational path from in_data.

## Test plan
- Reset behaviour:
  - Stimulus: assert rst mid-packet while out_valid=1 and in LOCKED.
  - Required: out_valid, out_data, out_last and out_src go to 0 immediately without a clock; in_ready=0000; after release the first grant goes to requester 0.
- Round-robin order:
  - Stimulus: NUM_REQ=4; in_valid=1111 held; all in_last=1; out_ready=1; in_data[i]=0xA0+i.
  - Required: out_data sequence 0xA0,0xA1,0xA2,0xA3,0xA0 on consecutive cycles; out_src 0,1,2,3,0.
- Packet lock:
  - Stimulus: requester 2 sends a 3-beat packet 0x10,0x11,0x12 with last on 0x12, while requester 1 is also valid.
  - Required: in_ready[1]=0 until 0x12 is accepted; out_src=2 for all three beats; next grant goes to requester 3 if valid, else 0, else 1 (search from rr_ptr=3).
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles while out_valid=1 with out_data=0x55.
  - Required: out_data stays 0x55; in_ready=0000 throughout; on out_ready=1 the next beat loads in the same cycle with no bubble.
- Owner bubble:
  - Stimulus: owner 0 deasserts in_valid for 2 cycles mid-packet while requester 3 is valid.
  - Required: out_valid falls to 0 after the pending beat drains; in_ready[3] stays 0 throughout; the packet completes from requester 0 before requester 3 is granted.
- Wrap and sparse requests:
  - Stimulus: only requester 3 valid (single beat), then only requester 1 valid.
  - Required: grant to 3 with rr_ptr wrapping to 0, then grant to 1 in the following cycle.
